sys_act_feeder: RTL and testbench
=================================

SYS_ACT_FEEDER -- requirements
Module: sys_act_feeder

Interface
REQ-001 The block SHALL have parameter SYS_ROW, default 16, meaning the number of array rows fed.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, meaning the activation element width.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the input vector buffer depth (power of two, >=2).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state is rising-edge.
REQ-005 The block SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: single-cycle request to begin a tile.
REQ-007 The block SHALL have port len, input, 16 bits: number of activation vectors in the tile, sampled with start.
REQ-008 The block SHALL have port act_valid, input, 1 bit: act_data holds a valid vector.
REQ-009 The block SHALL have port act_ready, output, 1 bit: the FIFO can accept a vector.
REQ-010 The block SHALL have port act_data, input, DATA_WIDTH x [0:SYS_ROW-1]: one activation per row.
REQ-011 The block SHALL have port row_in, output, DATA_WIDTH x [0:SYS_ROW-1]: skewed activation into each row's "in".
REQ-012 The block SHALL have port row_en, output, SYS_ROW bits: per-row enable into each row's en_in[0].
REQ-013 The block SHALL have port busy, output, 1 bit: the FSM is not IDLE.
REQ-014 The block SHALL have port done, output, 1 bit: single-cycle pulse at tile completion.

Function
REQ-015 The block SHALL accept a vector on any cycle where act_valid && act_ready, in any FSM state, including IDLE prefetch.
REQ-016 act_ready SHALL equal !fifo_full.
REQ-017 A vector accepted in cycle t SHALL NOT be popped before cycle t+1 (no FIFO bypass).
REQ-018 The FSM SHALL have states IDLE, STREAM and DRAIN.
REQ-019 IDLE->STREAM SHALL occur on start with len!=0; the block SHALL latch len into the issue counter.
REQ-020 start with len==0 in IDLE SHALL pulse done in the next cycle, stay IDLE and leave busy low.
REQ-021 start while busy SHALL be ignored.
REQ-022 In STREAM, the block SHALL pop one vector on each cycle the FIFO is non-empty and decrement the remaining count.
REQ-023 An empty FIFO in STREAM SHALL produce a bubble: row_en bit low and row_in zero for that wavefront; the count SHALL NOT decrement.
REQ-024 After the last pop, STREAM->DRAIN SHALL occur; DRAIN SHALL last exactly SYS_ROW-1 cycles and then go to IDLE, pulsing done on that IDLE-entry cycle.
REQ-025 Skew: element r of a vector popped in cycle p SHALL appear on row_in[r] with row_en[r]=1 in cycle p+1+r; all outputs SHALL be registered.
REQ-026 Bubbles SHALL propagate through the skew identically, so every row sees the same en/bubble sequence delayed by r.
REQ-027 Simultaneous push and pop SHALL be allowed; FIFO occupancy SHALL then be unchanged.
REQ-028 Read/write pointers SHALL wrap modulo FIFO_DEPTH, with one extra bit used to distinguish full from empty.

Reset
REQ-029 On rstn low, asynchronously: FSM=IDLE, FIFO emptied, counters zero, and every skew register data and enable cleared.
REQ-030 Outputs during and after reset SHALL be: row_in all zero, row_en=0, busy=0, done=0, act_ready=1 (first cycle after release).
REQ-031 Reset mid-tile SHALL discard all in-flight and buffered vectors, with no done pulse.

Structure
REQ-032 Package mmu_pkg SHALL hold the feeder state enum (IDLE/STREAM/DRAIN) and the default SYS_ROW/DATA_WIDTH constants shared with the array.
REQ-033 The FIFO SHALL be a sub-module sys_feeder_fifo (parameterised width/depth, full/empty flags); the skew triangle SHALL stay in the top level.

Verification
REQ-034 Bench: SYS_ROW=4, FIFO prefilled with vectors V0..V2 (V0={1,2,3,4}), start len=3 -> pops at cycles 1,2,3; row_in[3]=4 at cycle 5; done pulses at cycle 7.
REQ-035 Bench: len=2, V1 pushed 3 cycles after V0 -> two-cycle bubble with row_en[r] low for two cycles, identical per row offset by r; the count is unaffected.
REQ-036 Bench: hold act_valid=1 with no start, FIFO_DEPTH=4 -> act_ready falls after the 4th accept, and no vector is lost once the tile starts.
REQ-037 Bench: start len=0 -> done pulses 1 cycle later; busy stays 0; row_en stays 0.
REQ-038 Bench: assert rstn low during DRAIN -> row_en=0 immediately, FIFO empty, no done pulse; a subsequent tile of len=1 runs correctly.
REQ-039 Bench: pulse start again mid-STREAM with len=5 -> ignored; the original len completes with exactly one done.

Source files
------------

// File: rtl/mmu_pkg.sv
// rtl/mmu_pkg.sv - shared array constants and activation feeder state type
package mmu_pkg;

  localparam int SYS_ROW_DEFAULT    = 16;
  localparam int DATA_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/sys_act_feeder_if.sv
// rtl/sys_act_feeder_if.sv - activation vector stream into the feeder
interface sys_act_feeder_if #(
  parameter int SYS_ROW    = mmu_pkg::SYS_ROW_DEFAULT,
  parameter int DATA_WIDTH = mmu_pkg::DATA_WIDTH_DEFAULT
);

  logic                                 act_valid;
  logic                                 act_ready;
  logic [0:SYS_ROW-1][DATA_WIDTH-1:0]   act_data;

  modport master (
    output act_valid,
    output act_data,
    input  act_ready
  );

  modport slave (
    input  act_valid,
    input  act_data,
    output act_ready
  );

endinterface

// File: rtl/sys_feeder_fifo.sv
// rtl/sys_feeder_fifo.sv - registered vector FIFO; written data is visible only from the next cycle
module sys_feeder_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push, pop;

  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign empty   = (wr_ptr == rd_ptr);
  // Extra pointer bit differs only when the writer has lapped the reader.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/sys_act_feeder.sv
// rtl/sys_act_feeder.sv - activation feeder: vector FIFO, tile FSM and per-row skew triangle
module sys_act_feeder
  import mmu_pkg::*;
#(
  parameter int SYS_ROW    = SYS_ROW_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               start,
  input  logic [15:0]                        len,
  sys_act_feeder_if.slave                    act,
  output logic [0:SYS_ROW-1][DATA_WIDTH-1:0] row_in,
  output logic [SYS_ROW-1:0]                 row_en,
  output logic                               busy,
  output logic                               done
);

  localparam int DCW = (SYS_ROW > 1) ? $clog2(SYS_ROW) : 1;

  feeder_state_e                      state_q, state_d;
  logic [15:0]                        cnt_q, cnt_d;
  logic [DCW-1:0]                     drain_q, drain_d;
  logic                               done_d;
  logic                               pop;
  logic                               fifo_full, fifo_empty;
  logic [0:SYS_ROW-1][DATA_WIDTH-1:0] fifo_rd;

  sys_feeder_fifo #(
    .WIDTH (SYS_ROW * DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (act.act_valid),
    .wr_data (act.act_data),
    .full    (fifo_full),
    .rd_en   (pop),
    .rd_data (fifo_rd),
    .empty   (fifo_empty)
  );

  assign act.act_ready = !fifo_full;
  assign busy          = (state_q != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      drain_q <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len == 16'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = STREAM;
            cnt_d   = len;
          end
        end
      end
      STREAM: begin
        if (!fifo_empty) begin
          pop   = 1'b1;
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            // Drain lets the last wavefront reach the bottom row before done.
            if (SYS_ROW > 1) begin
              state_d = DRAIN;
              drain_d = DCW'(SYS_ROW - 1);
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
      DRAIN: begin
        drain_d = drain_q - DCW'(1);
        if (drain_q == DCW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Row r holds r+1 stages, so every row sees the same pop/bubble stream delayed by r.
  for (genvar r = 0; r < SYS_ROW; r++) begin : g_row
    logic [DATA_WIDTH-1:0] d_q  [0:r];
    logic                  en_q [0:r];

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int k = 0; k <= r; k++) begin
          d_q[k]  <= '0;
          en_q[k] <= 1'b0;
        end
      end else begin
        d_q[0]  <= pop ? fifo_rd[r] : '0;
        en_q[0] <= pop;
        for (int k = 1; k <= r; k++) begin
          d_q[k]  <= d_q[k-1];
          en_q[k] <= en_q[k-1];
        end
      end
    end

    assign row_in[r] = d_q[r];
    assign row_en[r] = en_q[r];
  end

endmodule

// File: tb/tb_sys_act_feeder.sv
// tb/tb_sys_act_feeder.sv - self-checking bench for sys_act_feeder
module tb_sys_act_feeder;

  localparam int SYS_ROW    = 4;
  localparam int DATA_WIDTH = 16;
  localparam int DEPTH      = 4;

  typedef logic [0:SYS_ROW-1][DATA_WIDTH-1:0] vec_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [15:0] len;
  vec_t        row_in;
  logic [SYS_ROW-1:0] row_en;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  sys_act_feeder_if #(.SYS_ROW(SYS_ROW), .DATA_WIDTH(DATA_WIDTH)) ifc ();

  sys_act_feeder #(
    .SYS_ROW    (SYS_ROW),
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .start  (start),
    .len    (len),
    .act    (ifc),
    .row_in (row_in),
    .row_en (row_en),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act_v, exp_v, $time);
    end
  endtask

  function automatic vec_t mkvec(input int base);
    vec_t v;
    for (int i = 0; i < SYS_ROW; i++) v[i] = 16'(base + i);
    return v;
  endfunction

  // Source driver: presents queued vectors, advancing only after an observed accept.
  vec_t pending[$];
  bit   acc = 1'b0;

  always @(negedge clk) acc = rstn && ifc.act_valid && ifc.act_ready;

  initial begin
    ifc.act_valid = 1'b0;
    ifc.act_data  = '0;
    forever begin
      @(posedge clk);
      #2;
      if (acc && pending.size() > 0) void'(pending.pop_front());
      acc = 1'b0;
      if (pending.size() > 0) begin
        ifc.act_valid = 1'b1;
        ifc.act_data  = pending[0];
      end else begin
        ifc.act_valid = 1'b0;
        ifc.act_data  = '0;
      end
    end
  end

  // Reference model: FIFO as a queue, tile as a remaining count plus a drain
  // countdown, and a history of issued wavefronts that row r sees r cycles late.
  vec_t       q_m[$];
  int         remaining = 0;
  int         drain_left = 0;
  bit         done_m = 1'b0;
  vec_t       hist_d [0:SYS_ROW-1];
  logic [SYS_ROW-1:0] hist_e = '0;

  always @(negedge clk) begin : model
    vec_t er, w;
    bit   do_pop, do_push;
    if (!rstn) begin
      q_m.delete();
      remaining  = 0;
      drain_left = 0;
      done_m     = 1'b0;
      hist_e     = '0;
      for (int i = 0; i < SYS_ROW; i++) hist_d[i] = '0;
    end else begin
      for (int r = 0; r < SYS_ROW; r++) er[r] = hist_d[r][r];
      chk("m_row_in", row_in, er);
      chk("m_row_en", row_en, hist_e);
      chk("m_busy", busy, (remaining > 0 || drain_left > 0));
      chk("m_done", done, done_m);
      chk("m_act_ready", ifc.act_ready, (q_m.size() < DEPTH));

      done_m  = 1'b0;
      do_pop  = (remaining > 0) && (q_m.size() > 0);
      do_push = ifc.act_valid && (q_m.size() < DEPTH);
      w = '0;
      if (do_pop) w = q_m.pop_front();
      if (do_push) q_m.push_back(ifc.act_data);
      for (int r = SYS_ROW - 1; r > 0; r--) begin
        hist_d[r] = hist_d[r-1];
        hist_e[r] = hist_e[r-1];
      end
      hist_d[0] = w;
      hist_e[0] = do_pop;

      if (remaining > 0) begin
        if (do_pop) begin
          remaining--;
          if (remaining == 0) begin
            drain_left = SYS_ROW - 1;
            if (drain_left == 0) done_m = 1'b1;
          end
        end
      end else if (drain_left > 0) begin
        drain_left--;
        if (drain_left == 0) done_m = 1'b1;
      end else if (start) begin
        if (len == 16'd0) done_m = 1'b1;
        else remaining = int'(len);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fed();
    int n = 0;
    while ((pending.size() != 0 || ifc.act_valid) && n < 50) begin
      step();
      n++;
    end
    chk("feed_timeout", (n < 50), 1);
  endtask

  task automatic wait_idle(output int en_cnt);
    int n = 0;
    en_cnt = 0;
    do begin
      if (row_en[0]) en_cnt++;
      step();
      n++;
    end while (busy && n < 100);
    chk("idle_timeout", (n < 100), 1);
  endtask

  // Walks cycles 1..9 after the start cycle against a hand-computed row_en table.
  task automatic check_tile(input string nm, input logic [3:0] tab [0:9], input int done_c);
    for (int c = 1; c <= 9; c++) begin
      chk({nm, "_row_en"}, row_en, tab[c]);
      chk({nm, "_done"}, done, (c == done_c));
      chk({nm, "_busy"}, busy, (c < done_c));
      step();
    end
  endtask

  logic [3:0] t1_en [0:9] = '{4'd0, 4'd0, 4'd1, 4'd3, 4'd7, 4'd14, 4'd12, 4'd8, 4'd0, 4'd0};
  logic [3:0] t2_en [0:9] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd4, 4'd9, 4'd2, 4'd4, 4'd8, 4'd0};
  logic [3:0] t5_en [0:9] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd4, 4'd8, 4'd0, 4'd0, 4'd0, 4'd0};

  initial begin
    int cnt;
    int done_seen;
    rstn  = 1'b0;
    start = 1'b0;
    len   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_row_in", row_in, 64'd0);
    chk("rst_row_en", row_en, 4'd0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_act_ready", ifc.act_ready, 1);
    rstn = 1'b1;
    step();

    // Prefilled tile of three vectors, V0 = {1,2,3,4}.
    pending.push_back(mkvec(1));
    pending.push_back(mkvec(5));
    pending.push_back(mkvec(9));
    wait_fed();
    start = 1'b1; len = 16'd3;
    step();
    start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      chk("t1_row_en", row_en, t1_en[c]);
      chk("t1_done", done, (c == 7));
      chk("t1_busy", busy, (c <= 6));
      if (c == 5) chk("t1_row3_c5", row_in[3], 16'd4);
      if (c == 7) chk("t1_row3_c7", row_in[3], 16'd12);
      step();
    end

    // Two-cycle bubble: V1 arrives three cycles after V0.
    step();
    pending.push_back(mkvec(21));
    start = 1'b1; len = 16'd2;
    step();
    start = 1'b0;
    step();
    step();
    pending.push_back(mkvec(31));
    chk("t2_row_en_c3", row_en, 4'b0010);
    step();
    chk("t2_row_en_c4", row_en, 4'b0100);
    step();
    chk("t2_row0_c5", row_in[0], 16'd31);
    chk("t2_row3_c5", row_in[3], 16'd24);
    repeat (2) step();
    chk("t2_done_c7", done, 0);
    step();
    chk("t2_done_c8", done, 1);
    repeat (2) step();
    check_tile("t2chk_idle", '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}, 0);

    // Backpressure: valid held with no tile running.
    for (int k = 0; k < 6; k++) pending.push_back(mkvec(40 + 4 * k));
    repeat (3) step();
    chk("t3_ready_c3", ifc.act_ready, 1);
    step();
    chk("t3_ready_c4", ifc.act_ready, 0);
    step();
    chk("t3_ready_c5", ifc.act_ready, 0);
    chk("t3_valid_held", ifc.act_valid, 1);
    start = 1'b1; len = 16'd6;
    step();
    start = 1'b0;
    wait_idle(cnt);
    chk("t3_pop_count", cnt, 6);
    chk("t3_all_fed", pending.size(), 0);
    step();

    // Zero-length tile.
    start = 1'b1; len = 16'd0;
    step();
    start = 1'b0;
    chk("t4_done_c1", done, 1);
    chk("t4_busy_c1", busy, 0);
    chk("t4_row_en_c1", row_en, 4'd0);
    step();
    chk("t4_done_c2", done, 0);
    chk("t4_busy_c2", busy, 0);
    step();

    // Reset while draining, then a fresh single-vector tile.
    pending.push_back(mkvec(61));
    pending.push_back(mkvec(65));
    wait_fed();
    start = 1'b1; len = 16'd2;
    step();
    start = 1'b0;
    repeat (3) step();
    chk("t5_busy_drain", busy, 1);
    chk("t5_row_en_pre", row_en, 4'b0110);
    rstn = 1'b0;
    #1;
    chk("t5_rst_row_en", row_en, 4'd0);
    chk("t5_rst_row_in", row_in, 64'd0);
    chk("t5_rst_ready", ifc.act_ready, 1);
    chk("t5_rst_busy", busy, 0);
    repeat (2) step();
    rstn = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (done) done_seen++;
      step();
    end
    chk("t5_no_done", done_seen, 0);
    pending.push_back(mkvec(71));
    start = 1'b1; len = 16'd1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      chk("t5_row_en", row_en, t5_en[c]);
      chk("t5_done", done, (c == 5));
      if (c == 5) chk("t5_row3_c5", row_in[3], 16'd74);
      step();
    end

    // Restart while streaming is ignored.
    pending.push_back(mkvec(81));
    pending.push_back(mkvec(85));
    pending.push_back(mkvec(89));
    wait_fed();
    start = 1'b1; len = 16'd3;
    step();
    start = 1'b0;
    step();
    start = 1'b1; len = 16'd5;
    step();
    start = 1'b0; len = 16'd0;
    done_seen = 0;
    for (int c = 3; c <= 14; c++) begin
      if (done) done_seen++;
      chk("t6_done", done, (c == 7));
      step();
    end
    chk("t6_done_count", done_seen, 1);
    chk("t6_busy_end", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
